alu_cmd_sequencer: RTL and testbench

- Command front-end that sits directly upstream of the 16-bit ALU.
- Takes a byte stream from the UART RX path and assembles operands and a 4-bit function code.
- Drives and enables the ALU, captures the result and flags, then returns them as a 3-byte response to the UART TX path over a valid/ready handshake.
- Holds alu_en low whenever no operation is in flight, so the ALU clock gate stays closed.

---
 rtl/alu_cmd_sequencer_if.sv | 31 +++
 rtl/alu_cmd_sequencer.sv | 155 +++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/alu_cmd_sequencer_if.sv
// rtl/alu_cmd_sequencer_if.sv - rx byte stream, ALU drive/result bus and tx response stream
interface alu_cmd_sequencer_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_fun;
  logic        alu_en;
  logic [15:0] alu_out;
  logic        arith_flag;
  logic        logic_flag;
  logic        cmp_flag;
  logic        shift_flag;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        err;

  // sequencer side
  modport master (
    input  rx_data, rx_valid, alu_out, arith_flag, logic_flag, cmp_flag, shift_flag, tx_ready,
    output alu_a, alu_b, alu_fun, alu_en, tx_data, tx_valid, busy, err
  );

  // UART / ALU side
  modport slave (
    output rx_data, rx_valid, alu_out, arith_flag, logic_flag, cmp_flag, shift_flag, tx_ready,
    input  alu_a, alu_b, alu_fun, alu_en, tx_data, tx_valid, busy, err
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - assembles ALU commands from rx bytes and returns result/flags as 3 tx bytes
module alu_cmd_sequencer #(
  parameter int unsigned ALU_LAT  = 1,
  parameter logic [7:0]  CMD_OPS  = 8'hCC,
  parameter logic [7:0]  CMD_NOOP = 8'hDD
) (
  input logic                   clk,
  input logic                   rst_n,
  alu_cmd_sequencer_if.master   bus
);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] GET_ALO  = 4'd1;
  localparam logic [3:0] GET_AHI  = 4'd2;
  localparam logic [3:0] GET_BLO  = 4'd3;
  localparam logic [3:0] GET_BHI  = 4'd4;
  localparam logic [3:0] GET_FUN  = 4'd5;
  localparam logic [3:0] EXEC     = 4'd6;
  localparam logic [3:0] SEND_LO  = 4'd7;
  localparam logic [3:0] SEND_HI  = 4'd8;
  localparam logic [3:0] SEND_FLG = 4'd9;

  // last value of the EXEC edge counter; ALU_LAT is limited to 1..7
  localparam logic [2:0] LAT_LAST = 3'(ALU_LAT - 1);

  logic [3:0]  state;
  logic [2:0]  exec_cnt;
  logic [15:0] a_reg;
  logic [15:0] b_reg;
  logic [3:0]  fun_reg;
  logic        en_reg;
  logic [7:0]  res_hi;
  logic [7:0]  flg;
  logic [7:0]  tx_data_reg;
  logic        tx_valid_reg;
  logic        err_reg;
  logic        in_flight;

  // bytes arriving while executing or sending cannot be used and are flagged
  assign in_flight = (state == EXEC) || (state == SEND_LO) ||
                     (state == SEND_HI) || (state == SEND_FLG);

  // command framing, execution timing and response sequencing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      exec_cnt     <= 3'd0;
      a_reg        <= 16'd0;
      b_reg        <= 16'd0;
      fun_reg      <= 4'd0;
      en_reg       <= 1'b0;
      res_hi       <= 8'd0;
      flg          <= 8'd0;
      tx_data_reg  <= 8'd0;
      tx_valid_reg <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      err_reg <= bus.rx_valid && in_flight;
      case (state)
        IDLE: begin
          if (bus.rx_valid) begin
            if (bus.rx_data == CMD_OPS) begin
              state <= GET_ALO;
            end else if (bus.rx_data == CMD_NOOP) begin
              state <= GET_FUN;
            end else begin
              err_reg <= 1'b1;
            end
          end
        end
        GET_ALO: begin
          if (bus.rx_valid) begin
            a_reg[7:0] <= bus.rx_data;
            state      <= GET_AHI;
          end
        end
        GET_AHI: begin
          if (bus.rx_valid) begin
            a_reg[15:8] <= bus.rx_data;
            state       <= GET_BLO;
          end
        end
        GET_BLO: begin
          if (bus.rx_valid) begin
            b_reg[7:0] <= bus.rx_data;
            state      <= GET_BHI;
          end
        end
        GET_BHI: begin
          if (bus.rx_valid) begin
            b_reg[15:8] <= bus.rx_data;
            state       <= GET_FUN;
          end
        end
        GET_FUN: begin
          if (bus.rx_valid) begin
            if (bus.rx_data[7:4] == 4'd0) begin
              fun_reg  <= bus.rx_data[3:0];
              en_reg   <= 1'b1;
              exec_cnt <= 3'd0;
              state    <= EXEC;
            end else begin
              err_reg <= 1'b1;
              state   <= IDLE;
            end
          end
        end
        EXEC: begin
          if (exec_cnt == LAT_LAST) begin
            res_hi       <= bus.alu_out[15:8];
            flg          <= {4'b0, bus.arith_flag, bus.logic_flag, bus.cmp_flag, bus.shift_flag};
            tx_data_reg  <= bus.alu_out[7:0];
            tx_valid_reg <= 1'b1;
            en_reg       <= 1'b0;
            state        <= SEND_LO;
          end else begin
            exec_cnt <= exec_cnt + 3'd1;
          end
        end
        SEND_LO: begin
          if (bus.tx_ready) begin
            tx_data_reg <= res_hi;
            state       <= SEND_HI;
          end
        end
        SEND_HI: begin
          if (bus.tx_ready) begin
            tx_data_reg <= flg;
            state       <= SEND_FLG;
          end
        end
        SEND_FLG: begin
          if (bus.tx_ready) begin
            tx_valid_reg <= 1'b0;
            tx_data_reg  <= 8'd0;
            state        <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.alu_a    = a_reg;
  assign bus.alu_b    = b_reg;
  assign bus.alu_fun  = fun_reg;
  assign bus.alu_en   = en_reg;
  assign bus.tx_data  = tx_data_reg;
  assign bus.tx_valid = tx_valid_reg;
  assign bus.err      = err_reg;
  assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - directed bench for alu_cmd_sequencer with a small ALU model
module tb_alu_cmd_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int en_total = 0;
  int err_total = 0;
  int en_snap;
  int err_snap;

  alu_cmd_sequencer_if bus ();

  alu_cmd_sequencer #(.ALU_LAT(1), .CMD_OPS(8'hCC), .CMD_NOOP(8'hDD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // ALU stand-in: class chosen by fun[3:2] (arith, logic, compare, shift)
  always_comb begin
    bus.alu_out    = 16'd0;
    bus.arith_flag = 1'b0;
    bus.logic_flag = 1'b0;
    bus.cmp_flag   = 1'b0;
    bus.shift_flag = 1'b0;
    if (bus.alu_en) begin
      case (bus.alu_fun)
        4'h0: bus.alu_out = bus.alu_a + bus.alu_b;
        4'h1: bus.alu_out = bus.alu_a - bus.alu_b;
        4'h2: bus.alu_out = bus.alu_a & bus.alu_b;
        4'h3: bus.alu_out = bus.alu_a | bus.alu_b;
        4'hA: bus.alu_out = {15'd0, bus.alu_a == bus.alu_b};
        4'hE: bus.alu_out = bus.alu_a << 1;
        default: bus.alu_out = 16'd0;
      endcase
      bus.arith_flag = (bus.alu_fun[3:2] == 2'd0);
      bus.logic_flag = (bus.alu_fun[3:2] == 2'd1);
      bus.cmp_flag   = (bus.alu_fun[3:2] == 2'd2);
      bus.shift_flag = (bus.alu_fun[3:2] == 2'd3);
    end
  end

  // running tallies of alu_en cycles and err pulses
  always @(negedge clk) begin
    if (bus.alu_en === 1'b1) en_total++;
    if (bus.err === 1'b1) err_total++;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_ops(input logic [15:0] a, input logic [15:0] b, input logic [7:0] f);
    send_byte(8'hCC);
    send_byte(a[7:0]);
    send_byte(a[15:8]);
    send_byte(b[7:0]);
    send_byte(b[15:8]);
    send_byte(f);
  endtask

  task automatic expect_resp(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2);
    logic [7:0] exp_b [3];
    exp_b[0] = e0;
    exp_b[1] = e1;
    exp_b[2] = e2;
    for (int i = 0; i < 3; i++) begin
      int n = 0;
      while (bus.tx_valid !== 1'b1 && n < 50) begin
        @(negedge clk);
        n++;
      end
      check({tag, "_valid"}, 16'(bus.tx_valid), 16'd1);
      check($sformatf("%s_byte%0d", tag, i), 16'(bus.tx_data), 16'(exp_b[i]));
      @(negedge clk);
    end
    check({tag, "_done"}, 16'(bus.tx_valid), 16'd0);
  endtask

  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_alu_a", bus.alu_a, 16'd0);
    check("rst_alu_b", bus.alu_b, 16'd0);
    check("rst_fun", 16'(bus.alu_fun), 16'd0);
    check("rst_en", 16'(bus.alu_en), 16'd0);
    check("rst_tx_valid", 16'(bus.tx_valid), 16'd0);
    check("rst_tx_data", 16'(bus.tx_data), 16'd0);
    check("rst_busy", 16'(bus.busy), 16'd0);
    check("rst_err", 16'(bus.err), 16'd0);
    rst_n = 1'b1;

    // add 1 + 1 with latency and enable-width checks
    en_snap = en_total;
    send_ops(16'h0001, 16'h0001, 8'h00);
    check("add_en_exec", 16'(bus.alu_en), 16'd1);
    check("add_txv_early", 16'(bus.tx_valid), 16'd0);
    @(negedge clk);
    check("add_txv_lat", 16'(bus.tx_valid), 16'd1);
    expect_resp("add", 8'h02, 8'h00, 8'h08);
    check("add_en_cycles", 16'(en_total - en_snap), 16'd1);
    check("add_busy_after", 16'(bus.busy), 16'd0);

    // subtract with stored operands
    send_byte(8'hDD);
    send_byte(8'h01);
    expect_resp("sub", 8'h00, 8'h00, 8'h08);
    check("sub_a_kept", bus.alu_a, 16'h0001);
    check("sub_b_kept", bus.alu_b, 16'h0001);

    // compare equal, then shift stored A
    send_ops(16'h0001, 16'h0001, 8'h0A);
    expect_resp("cmp", 8'h01, 8'h00, 8'h02);
    send_byte(8'hDD);
    send_byte(8'h0E);
    expect_resp("shl", 8'h02, 8'h00, 8'h01);

    // unknown command byte in IDLE
    err_snap = err_total;
    send_byte(8'h55);
    check("bad_cmd_err", 16'(bus.err), 16'd1);
    check("bad_cmd_busy", 16'(bus.busy), 16'd0);
    @(negedge clk);
    check("bad_cmd_err_pulse", 16'(bus.err), 16'd0);
    check("bad_cmd_err_count", 16'(err_total - err_snap), 16'd1);

    // bad function byte aborts the frame
    err_snap = err_total;
    send_ops(16'h0001, 16'h0001, 8'h1F);
    check("bad_fun_err", 16'(bus.err), 16'd1);
    repeat (5) @(negedge clk);
    check("bad_fun_no_tx", 16'(bus.tx_valid), 16'd0);
    check("bad_fun_idle", 16'(bus.busy), 16'd0);
    check("bad_fun_err_count", 16'(err_total - err_snap), 16'd1);

    // back-pressure in SEND_LO plus an overrun byte
    bus.tx_ready = 1'b0;
    send_ops(16'h0001, 16'h0001, 8'h00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("stall_valid%0d", i), 16'(bus.tx_valid), 16'd1);
      check($sformatf("stall_data%0d", i), 16'(bus.tx_data), 16'h0002);
    end
    err_snap = err_total;
    send_byte(8'h77);
    check("overrun_err", 16'(bus.err), 16'd1);
    check("overrun_data", 16'(bus.tx_data), 16'h0002);
    check("overrun_busy", 16'(bus.busy), 16'd1);
    bus.tx_ready = 1'b1;
    expect_resp("stall", 8'h02, 8'h00, 8'h08);
    check("overrun_err_count", 16'(err_total - err_snap), 16'd1);

    // asynchronous reset while executing
    send_ops(16'h0001, 16'h0001, 8'h00);
    check("pre_rst_en", 16'(bus.alu_en), 16'd1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_en", 16'(bus.alu_en), 16'd0);
    check("arst_a", bus.alu_a, 16'd0);
    check("arst_busy", 16'(bus.busy), 16'd0);
    check("arst_txv", 16'(bus.tx_valid), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_no_tx", 16'(bus.tx_valid), 16'd0);
    check("post_rst_idle", 16'(bus.busy), 16'd0);
    send_ops(16'h0003, 16'h0002, 8'h01);
    expect_resp("post_rst", 8'h01, 8'h00, 8'h08);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
